legv8_multicycle_control: RTL
=============================

# legv8_multicycle_control

Multi-cycle control unit for the LEGv8 core. It sequences a shared-ALU, shared-memory datapath one instruction at a time: fetch, decode, execute, memory access and write-back. It drives the datapath mux selects and the register-file, IR, PC and memory enables from the IR opcode, the ALU zero flag and a memory ready handshake. It also counts retired instructions and flags illegal opcodes and memory timeouts.

## Interface
- MEM_TIMEOUT, 16: maximum cycles to wait for iMemReady in any memory state.
- CNT_W, 32: width of the retired-instruction counter.
- iCLK in 1: clock, rising edge.
- iRST in 1: synchronous, active-high reset.
- iOpcode in 11: IR[31:21]; `OPC_*` values come from Parametros.v.
- iZero in 1: ALU zero flag.
- iMemReady in 1: memory completes the current access this cycle.
- oIorD out 1: memory address select; 0=PC, 1=ALUOut.
- oMemRead out 1: memory read strobe.
- oMemWrite out 1: memory write strobe.
- oIRWrite out 1: latch IR.
- oPCWrite out 1: load PC.
- oPCSrc out 1: PC source; 0=ALU result, 1=ALUOut.
- oALUSrcA out 1: ALU A select; 0=PC, 1=reg A.
- oALUSrcB out 2: ALU B select; 0=reg B, 1=constant 4, 2=sign-extended immediate.
- oALUOp out 2: 0=add, 1=pass B, 2=funct from opcode.
- oReg2Loc out 1: second read-register select; 1=Rt.
- oRegWrite out 1: register-file write enable.
- oMemToReg out 1: write-back source; 1=MDR.
- oRetire out 1: one-cycle pulse when an instruction completes.
- oIllegal out 1: one-cycle pulse on an unsupported opcode.
- oBusErr out 1: one-cycle pulse on a memory timeout.
- oInstrCount out CNT_W: retired-instruction count.
- oState out 4: current state, for debug.

## Operation
States and their encodings:
- FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9.

Instruction classes, by `casez` on iOpcode, checked in descending order of fixed bits:
- R: OPC_R_ADD/SUB/AND/ORR.
- I: OPC_I_ADDI/SUBI/ANDI/ORRI.
- LOAD: OPC_D_LDUR/LDURB/LDURH/LDURSW.
- STORE: OPC_D_STUR/STURB/STURH/STURW.
- CBR: OPC_CB_CBZ/CBNZ.
- UB: OPC_B_B.
- Anything else is illegal, including OPC_CB_BCOND.

Outputs are Mealy; every output not listed for a state is 0.
- **FETCH**: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0.
  - iMemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, next state DECODE.
  - iMemReady=0: stay in FETCH.
- **DECODE**: ALUSrcA=0, ALUSrcB=2, ALUOp=0 (branch target into ALUOut). Reg2Loc=1 for STORE and CBR. Next state:
  - R → EXEC_R; I → EXEC_I; LOAD/STORE → ADDR; CBR/UB → BRANCH.
  - Illegal → FETCH with oIllegal=1 and no retire. PC already holds PC+4.
- **EXEC_R**: ALUSrcA=1, ALUSrcB=0, ALUOp=2 → WB_ALU.
- **EXEC_I**: ALUSrcA=1, ALUSrcB=2, ALUOp=2 → WB_ALU.
- **ADDR**: ALUSrcA=1, ALUSrcB=2, ALUOp=0, Reg2Loc=1 → MEM_RD for LOAD, MEM_WR for STORE.
- **MEM_RD**: IorD=1, MemRead=1. Leaves on iMemReady → WB_MEM.
- **MEM_WR**: IorD=1, MemWrite=1, Reg2Loc=1. Leaves on iMemReady → FETCH with Retire=1.
- **WB_ALU**: RegWrite=1, MemToReg=0, Retire=1 → FETCH.
- **WB_MEM**: RegWrite=1, MemToReg=1, Retire=1 → FETCH.
- **BRANCH**: ALUSrcA=1, ALUSrcB=0, ALUOp=1, Reg2Loc=1, PCSrc=1, Retire=1 → FETCH.
  - PCWrite=1 when UB, or CBZ with iZero=1, or CBNZ with iZero=0.

Wait counter (memory states FETCH, MEM_RD, MEM_WR):
- Clears on entry to any memory state.
- Increments each cycle iMemReady=0.
- Reaching MEM_TIMEOUT-1 with iMemReady=0: BusErr=1 and next state FETCH. No IRWrite, PCWrite, RegWrite or retire. The strobe drops the next cycle.

Retired-instruction counter:
- oInstrCount increments on each Retire.
- Wraps from 2^CNT_W-1 to 0.

## Timing
- Reset: while iRST=1 at a rising edge, state←FETCH, wait counter←0 and oInstrCount←0.
- While iRST is high, every control output is forced to 0. This includes MemRead, so there is no fetch during reset. oState reads 0.
- First fetch strobe: the cycle after iRST falls.
- iRST asserted mid-instruction aborts on the next edge. A pending MemWrite that did not see iMemReady is dropped and no retire is counted.
- Latency with zero-wait memory (iMemReady=1 on the first strobe cycle), edge to edge:
  - R / I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - CBR / UB: 3 cycles.
  - Illegal: 2 cycles.
  - Each wait cycle adds 1.
- iMemReady is sampled only in memory states and ignored elsewhere.
- Retire and the counter update are on the same edge. oInstrCount shows the new value the following cycle.

## Test plan
- Reset, then ADD with zero-wait memory:
  - States 0,1,2,7, then 0.
  - RegWrite=1 only in state 7.
  - oInstrCount 0→1.
- LDUR with 3 wait cycles in MEM_RD:
  - 8 cycles total.
  - MemRead held high with IorD=1 through all waits.
  - WB_MEM asserts MemToReg=1.
- CBZ with iZero=1 and CBNZ with iZero=1:
  - CBZ: PCWrite=1, PCSrc=1 in BRANCH.
  - CBNZ: PCWrite=0. Both retire.
- Opcode 11'h000 (illegal):
  - oIllegal pulses in DECODE, back to FETCH.
  - oInstrCount unchanged.
- MEM_TIMEOUT=4, iMemReady=0 in FETCH:
  - oBusErr pulses on the 4th cycle, then re-fetch.
  - IRWrite never asserted.
- STUR, with iRST asserted during MEM_WR and CNT_W=4 preset to 15:
  - Next cycle all outputs 0 and state 0.
  - Separately, a completing STUR wraps oInstrCount from 15 to 0.

Source files
------------

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/exec/mem/wb sequencing.
// Ports: iCLK/iRST, iOpcode/iZero/iMemReady in; datapath selects/enables, oRetire/oIllegal/oBusErr pulses, oInstrCount, oState out.
module legv8_multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [10:0]      iOpcode,
    input  logic             iZero,
    input  logic             iMemReady,
    output logic             oIorD,
    output logic             oMemRead,
    output logic             oMemWrite,
    output logic             oIRWrite,
    output logic             oPCWrite,
    output logic             oPCSrc,
    output logic             oALUSrcA,
    output logic [1:0]       oALUSrcB,
    output logic [1:0]       oALUOp,
    output logic             oReg2Loc,
    output logic             oRegWrite,
    output logic             oMemToReg,
    output logic             oRetire,
    output logic             oIllegal,
    output logic             oBusErr,
    output logic [CNT_W-1:0] oInstrCount,
    output logic [3:0]       oState
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_ALU = 4'd7,
        WB_MEM = 4'd8,
        BRANCH = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_CBR, CLS_UB, CLS_ILL
    } cls_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              bus_err;
    cls_t              cls;

    // Most specific patterns first: 11-bit, then 10, 8 and 6 fixed bits.
    function automatic cls_t classify(input logic [10:0] op);
        cls_t c;
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: c = CLS_R;
            11'b11111000010, 11'b00111000010,
            11'b01111000010, 11'b10111000100: c = CLS_LOAD;
            11'b11111000000, 11'b00111000000,
            11'b01111000000, 11'b10111000000: c = CLS_STORE;
            11'b1001000100?, 11'b1101000100?,
            11'b1001001000?, 11'b1011001000?: c = CLS_I;
            11'b10110100???, 11'b10110101???: c = CLS_CBR;
            11'b000101?????:                  c = CLS_UB;
            default:                          c = CLS_ILL;
        endcase
        return c;
    endfunction

    assign cls     = classify(iOpcode);
    assign timeout = (wait_cnt == WAIT_MAX) && !iMemReady;

    always_comb begin
        next_state = state;
        bus_err    = 1'b0;
        oIorD      = 1'b0;
        oMemRead   = 1'b0;
        oMemWrite  = 1'b0;
        oIRWrite   = 1'b0;
        oPCWrite   = 1'b0;
        oPCSrc     = 1'b0;
        oALUSrcA   = 1'b0;
        oALUSrcB   = 2'd0;
        oALUOp     = 2'd0;
        oReg2Loc   = 1'b0;
        oRegWrite  = 1'b0;
        oMemToReg  = 1'b0;
        oRetire    = 1'b0;
        oIllegal   = 1'b0;
        unique case (state)
            FETCH: begin
                oMemRead = 1'b1;
                oALUSrcB = 2'd1;
                if (iMemReady) begin
                    oIRWrite   = 1'b1;
                    oPCWrite   = 1'b1;
                    next_state = DECODE;
                end else if (timeout) begin
                    bus_err    = 1'b1;
                    next_state = FETCH;
                end
            end
            DECODE: begin
                // Branch target is formed here while the ALU is idle.
                oALUSrcB = 2'd2;
                oReg2Loc = (cls == CLS_STORE) || (cls == CLS_CBR);
                unique case (cls)
                    CLS_R:     next_state = EXEC_R;
                    CLS_I:     next_state = EXEC_I;
                    CLS_LOAD,
                    CLS_STORE: next_state = ADDR;
                    CLS_CBR,
                    CLS_UB:    next_state = BRANCH;
                    default: begin
                        oIllegal   = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                oALUSrcA   = 1'b1;
                oALUOp     = 2'd2;
                next_state = WB_ALU;
            end
            EXEC_I: begin
                oALUSrcA   = 1'b1;
                oALUSrcB   = 2'd2;
                oALUOp     = 2'd2;
                next_state = WB_ALU;
            end
            ADDR: begin
                oALUSrcA   = 1'b1;
                oALUSrcB   = 2'd2;
                oReg2Loc   = 1'b1;
                next_state = (cls == CLS_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                oIorD    = 1'b1;
                oMemRead = 1'b1;
                if (iMemReady) begin
                    next_state = WB_MEM;
                end else if (timeout) begin
                    bus_err    = 1'b1;
                    next_state = FETCH;
                end
            end
            MEM_WR: begin
                oIorD     = 1'b1;
                oMemWrite = 1'b1;
                oReg2Loc  = 1'b1;
                if (iMemReady) begin
                    oRetire    = 1'b1;
                    next_state = FETCH;
                end else if (timeout) begin
                    bus_err    = 1'b1;
                    next_state = FETCH;
                end
            end
            WB_ALU: begin
                oRegWrite  = 1'b1;
                oRetire    = 1'b1;
                next_state = FETCH;
            end
            WB_MEM: begin
                oRegWrite  = 1'b1;
                oMemToReg  = 1'b1;
                oRetire    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                oALUSrcA   = 1'b1;
                oALUOp     = 2'd1;
                oReg2Loc   = 1'b1;
                oPCSrc     = 1'b1;
                oRetire    = 1'b1;
                // iOpcode[3] is IR[24]: set for CBNZ, clear for CBZ.
                oPCWrite   = (cls == CLS_UB) ||
                             ((cls == CLS_CBR) && (iOpcode[3] ? !iZero : iZero));
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
        oBusErr = bus_err;
        // Reset silences the datapath, including the fetch strobe.
        if (iRST) begin
            oIorD     = 1'b0;
            oMemRead  = 1'b0;
            oMemWrite = 1'b0;
            oIRWrite  = 1'b0;
            oPCWrite  = 1'b0;
            oPCSrc    = 1'b0;
            oALUSrcA  = 1'b0;
            oALUSrcB  = 2'd0;
            oALUOp    = 2'd0;
            oReg2Loc  = 1'b0;
            oRegWrite = 1'b0;
            oMemToReg = 1'b0;
            oRetire   = 1'b0;
            oIllegal  = 1'b0;
            oBusErr   = 1'b0;
        end
    end

    assign oState = iRST ? 4'd0 : state;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            oInstrCount <= '0;
        end else begin
            state <= next_state;
            // Any state change or timeout re-entry restarts the wait count.
            if ((next_state != state) || bus_err) begin
                wait_cnt <= '0;
            end else if (!iMemReady) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (oRetire) begin
                oInstrCount <= oInstrCount + CNT_W'(1);
            end
        end
    end

endmodule
